// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN single-layer datapath: FSM encoding, kernel size
// and the one-hot line-buffer selector helpers.
package cnn_pkg;

  localparam int         KSIZE        = 3;
  localparam logic [2:0] ONEHOT3_INIT = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_SWEEP  = 3'd2,
    S_REFILL = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  function automatic logic [2:0] rotl3(input logic [2:0] v);
    return {v[1:0], v[2]};
  endfunction

  // Index counters never shrink below one bit, even for a single-window axis.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_window_scheduler_onehot3_rotator.sv
// Three-bit one-hot selector for the line buffers: rotates left on en_i,
// synchronous load of 001 takes priority.
module onehot3_rotator
  import cnn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       en_i,
  output logic [2:0] q_o
);

  logic [2:0] q_q;
  logic [2:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = ONEHOT3_INIT;
    end else if (en_i) begin
      q_d = rotl3(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= ONEHOT3_INIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/conv_window_scheduler.sv
// Sequences the three line-buffer fills and the 3x3 window sweep toward the MAC,
// rotating the line buffer that holds the top window row after every refill.
module conv_window_scheduler
  import cnn_pkg::*;
#(
  parameter int IMG_W = 7,
  parameter int IMG_H = 7,
  parameter int K     = 3,
  localparam int OUT_W = IMG_W - K + 1,
  localparam int OUT_H = IMG_H - K + 1,
  localparam int CW    = clog2_min1(OUT_W),
  localparam int RW    = clog2_min1(OUT_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          fill_ack_i,
  input  logic          out_ready_i,
  output logic          fill_req_o,
  output logic [2:0]    fill_sel_o,
  output logic [2:0]    row_sel_o,
  output logic [CW-1:0] col_idx_o,
  output logic [RW-1:0] row_idx_o,
  output logic          win_valid_o,
  output logic          win_last_o,
  output logic          rc_en_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);

  generate
    if (K != KSIZE || IMG_W < KSIZE || IMG_H < KSIZE) begin : g_param_check
      $error("conv_window_scheduler: K must be 3 and the image at least 3x3");
    end
  endgenerate

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    fill_cnt_q, fill_cnt_d;

  logic       rot_load;
  logic       fill_rot_en;
  logic       row_rot_en;
  logic [2:0] fill_sel_q;
  logic [2:0] row_sel_q;
  logic       col_at_end;
  logic       row_at_end;

  assign col_at_end = (col_q == COL_LAST);
  assign row_at_end = (row_q == ROW_LAST);

  onehot3_rotator u_fill_sel (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (rot_load),
    .en_i   (fill_rot_en),
    .q_o    (fill_sel_q)
  );

  onehot3_rotator u_row_sel (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (rot_load),
    .en_i   (row_rot_en),
    .q_o    (row_sel_q)
  );

  // Abort outranks everything, so selectors and counters fall back to their
  // reset values on the very next edge, whatever the current state.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    fill_cnt_d  = fill_cnt_q;
    rot_load    = 1'b0;
    fill_rot_en = 1'b0;
    row_rot_en  = 1'b0;
    if (abort_i) begin
      state_d    = S_IDLE;
      col_d      = '0;
      row_d      = '0;
      fill_cnt_d = '0;
      rot_load   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          rot_load   = 1'b1;
          col_d      = '0;
          row_d      = '0;
          fill_cnt_d = '0;
          if (start_i) begin
            state_d = S_FILL;
          end
        end
        S_FILL: begin
          if (fill_ack_i) begin
            fill_rot_en = 1'b1;
            if (fill_cnt_q == 2'd2) begin
              fill_cnt_d = '0;
              state_d    = S_SWEEP;
            end else begin
              fill_cnt_d = fill_cnt_q + 2'd1;
            end
          end
        end
        S_SWEEP: begin
          if (out_ready_i) begin
            if (!col_at_end) begin
              col_d = col_q + CW'(1);
            end else if (row_at_end) begin
              state_d = S_DONE;
            end else begin
              col_d   = '0;
              state_d = S_REFILL;
            end
          end
        end
        // The buffer holding the oldest (top) row is the one overwritten.
        S_REFILL: begin
          if (fill_ack_i) begin
            row_rot_en = 1'b1;
            row_d      = row_q + RW'(1);
            state_d    = S_SWEEP;
          end
        end
        S_DONE: begin
          rot_load = 1'b1;
          col_d    = '0;
          row_d    = '0;
          state_d  = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  assign fill_req_o  = (state_q == S_FILL) || (state_q == S_REFILL);
  assign fill_sel_o  = (state_q == S_REFILL) ? row_sel_q : fill_sel_q;
  assign row_sel_o   = row_sel_q;
  assign col_idx_o   = col_q;
  assign row_idx_o   = row_q;
  assign win_valid_o = (state_q == S_SWEEP);
  assign win_last_o  = (state_q == S_SWEEP) && col_at_end && row_at_end;
  assign rc_en_o     = win_valid_o && out_ready_i;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench for conv_window_scheduler: randomized fills/backpressure
// against an event-level model of the window sweep, plus a 3x3 minimum-size instance.
module tb_conv_window_scheduler;

  localparam int OUT_W = 5;
  localparam int OUT_H = 5;
  localparam int EXP_FILL = 1;
  localparam int EXP_WIN  = 2;
  localparam int EXP_DONE = 3;
  localparam logic [17:0] RESET_VEC = {1'b0, 3'b001, 3'b001, 3'd0, 3'd0, 5'b00000};

  logic       clk;
  logic       rst_n;
  logic       start_i, abort_i, fill_ack_i, out_ready_i;
  logic       fill_req, win_valid, win_last, rc_en, busy, done;
  logic [2:0] fill_sel, row_sel, col_idx, row_idx;

  logic       m_start, m_abort, m_fill_ack, m_out_ready;
  logic       m_fill_req, m_win_valid, m_win_last, m_rc_en, m_busy, m_done;
  logic [2:0] m_fill_sel, m_row_sel;
  logic [0:0] m_col_idx, m_row_idx;

  int compared;
  int mismatched;

  conv_window_scheduler #(.IMG_W(7), .IMG_H(7), .K(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .fill_ack_i  (fill_ack_i),
    .out_ready_i (out_ready_i),
    .fill_req_o  (fill_req),
    .fill_sel_o  (fill_sel),
    .row_sel_o   (row_sel),
    .col_idx_o   (col_idx),
    .row_idx_o   (row_idx),
    .win_valid_o (win_valid),
    .win_last_o  (win_last),
    .rc_en_o     (rc_en),
    .busy_o      (busy),
    .done_o      (done)
  );

  conv_window_scheduler #(.IMG_W(3), .IMG_H(3), .K(3)) dut_min (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (m_start),
    .abort_i     (m_abort),
    .fill_ack_i  (m_fill_ack),
    .out_ready_i (m_out_ready),
    .fill_req_o  (m_fill_req),
    .fill_sel_o  (m_fill_sel),
    .row_sel_o   (m_row_sel),
    .col_idx_o   (m_col_idx),
    .row_idx_o   (m_row_idx),
    .win_valid_o (m_win_valid),
    .win_last_o  (m_win_last),
    .rc_en_o     (m_rc_en),
    .busy_o      (m_busy),
    .done_o      (m_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [17:0] snap();
    return {fill_req, fill_sel, row_sel, col_idx, row_idx, win_valid, win_last, rc_en, busy, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic ack, input logic rdy);
    start_i     = st;
    abort_i     = ab;
    fill_ack_i  = ack;
    out_ready_i = rdy;
  endtask

  // One frame on the 7x7 instance. The model tracks only which phase must be visible
  // next (fill request, window, done) and the expected window / buffer targets.
  task automatic run_frame(input int readyMode, input int stallR, input int stallC, input int stallLen,
                           input int ackMode, input bit noise,
                           input int killMode, input int killR, input int killC);
    int expSt, fillsDone, curRow, curCol, waitCnt, ackDelay, stallLeft, rcCount, cycles;
    bit finished, killed;
    logic rdy, ack, st;
    logic [2:0] expSel;
    expSt = EXP_FILL; fillsDone = 0; curRow = 0; curCol = 0; waitCnt = 0;
    stallLeft = stallLen; rcCount = 0; cycles = 0; finished = 0; killed = 0;
    ackDelay = (ackMode == 0) ? 2 : int'($urandom_range(0, 3));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    while (!finished && cycles < 3000) begin
      cycles++;
      compared++;
      if ({busy, fill_req, win_valid, done} !==
          {1'b1, expSt == EXP_FILL, expSt == EXP_WIN, expSt == EXP_DONE}) begin
        mismatched++;
        $display("[TB] FAIL phase: got busy/req/valid/done=%b expected phase %0d at row %0d col %0d",
                 {busy, fill_req, win_valid, done}, expSt, curRow, curCol);
      end
      if (expSt == EXP_FILL) begin
        expSel = (fillsDone < 3) ? 3'(1 << fillsDone) : 3'(1 << ((curRow - 1) % 3));
        compared++;
        if (fill_sel !== expSel) begin
          mismatched++;
          $display("[TB] FAIL fill_sel: got %b expected %b (fill %0d, row %0d)", fill_sel, expSel, fillsDone, curRow);
        end
      end
      if (expSt == EXP_WIN) begin
        compared++;
        if ({row_idx, col_idx} !== {3'(curRow), 3'(curCol)}) begin
          mismatched++;
          $display("[TB] FAIL window_index: got (%0d,%0d) expected (%0d,%0d)", row_idx, col_idx, curRow, curCol);
        end
        compared++;
        if (row_sel !== 3'(1 << (curRow % 3))) begin
          mismatched++;
          $display("[TB] FAIL row_sel: got %b expected %b at row %0d", row_sel, 3'(1 << (curRow % 3)), curRow);
        end
        compared++;
        if (win_last !== (curRow == OUT_H - 1 && curCol == OUT_W - 1)) begin
          mismatched++;
          $display("[TB] FAIL win_last: got %b at (%0d,%0d)", win_last, curRow, curCol);
        end
      end
      if (killMode != 0 && expSt == EXP_WIN && curRow == killR && curCol == killC) begin
        killed = 1;
        break;
      end
      ack = 1'b0;
      if (expSt == EXP_FILL) begin
        if (waitCnt >= ackDelay) ack = 1'b1;
        else waitCnt++;
      end else if (noise) begin
        ack = ($urandom_range(0, 2) == 0);
      end
      case (readyMode)
        0: rdy = 1'b1;
        1: begin
          rdy = 1'b1;
          if (expSt == EXP_WIN && curRow == stallR && curCol == stallC && stallLeft > 0) begin
            rdy = 1'b0;
            stallLeft--;
          end
        end
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      st = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      applyStimulus(st, 1'b0, ack, rdy);
      #1;
      compared++;
      if (rc_en !== (expSt == EXP_WIN && rdy)) begin
        mismatched++;
        $display("[TB] FAIL rc_en: got %b expected %b", rc_en, (expSt == EXP_WIN && rdy));
      end
      if (rc_en === 1'b1) rcCount++;
      case (expSt)
        EXP_FILL: if (ack) begin
          waitCnt = 0;
          if (ackMode != 0) ackDelay = int'($urandom_range(0, 3));
          if (fillsDone < 3) begin
            fillsDone++;
            if (fillsDone == 3) expSt = EXP_WIN;
          end else begin
            expSt = EXP_WIN;
          end
        end
        EXP_WIN: if (rdy) begin
          if (curCol < OUT_W - 1) curCol++;
          else if (curRow == OUT_H - 1) expSt = EXP_DONE;
          else begin
            curCol = 0;
            curRow++;
            expSt = EXP_FILL;
          end
        end
        default: finished = 1;
      endcase
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    if (killed && killMode == 1) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      abort_i = 1'b0;
      #1;
      compared++;
      if (snap() !== RESET_VEC) begin
        mismatched++;
        $display("[TB] FAIL abort_outputs: got %h expected %h", snap(), RESET_VEC);
      end
      for (int i = 0; i < 4; i++) begin
        tick();
        compared++;
        if ({busy, done} !== 2'b00) begin
          mismatched++;
          $display("[TB] FAIL abort_quiet: got busy/done=%b expected 00", {busy, done});
        end
      end
    end else if (killed) begin
      rst_n = 1'b0;
      #1;
      compared++;
      if (snap() !== RESET_VEC) begin
        mismatched++;
        $display("[TB] FAIL reset_outputs: got %h expected %h", snap(), RESET_VEC);
      end
      tick();
      rst_n = 1'b1;
      tick();
      compared++;
      if (snap() !== RESET_VEC) begin
        mismatched++;
        $display("[TB] FAIL reset_release: got %h expected %h", snap(), RESET_VEC);
      end
    end else if (!finished) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL frame_timeout: got no done within %0d cycles expected done", cycles);
    end else begin
      #1;
      compared++;
      if (snap() !== RESET_VEC) begin
        mismatched++;
        $display("[TB] FAIL idle_after_done: got %h expected %h", snap(), RESET_VEC);
      end
      compared++;
      if (rcCount != OUT_W * OUT_H) begin
        mismatched++;
        $display("[TB] FAIL rc_en_count: got %0d expected %0d", rcCount, OUT_W * OUT_H);
      end
    end
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    compared++;
    if (snap() !== RESET_VEC) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got %h expected %h", snap(), RESET_VEC);
    end
    rst_n = 1'b1;
    tick();
    compared++;
    if (snap() !== RESET_VEC) begin
      mismatched++;
      $display("[TB] FAIL idle_after_reset: got %h expected %h", snap(), RESET_VEC);
    end
  endtask

  task automatic test_default_frame();
    $display("[TB] default 7x7 frame");
    run_frame(0, 0, 0, 0, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    $display("[TB] backpressure at window (1,2)");
    run_frame(1, 1, 2, 5, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_abort();
    $display("[TB] abort at window (2,3)");
    run_frame(0, 0, 0, 0, 0, 1'b0, 1, 2, 3);
  endtask

  task automatic test_reset_mid_frame();
    $display("[TB] reset at window (2,3)");
    run_frame(0, 0, 0, 0, 0, 1'b0, 2, 2, 3);
  endtask

  task automatic test_ignored_inputs();
    $display("[TB] stray start and fill_ack pulses");
    run_frame(0, 0, 0, 0, 0, 1'b1, 0, 0, 0);
  endtask

  task automatic test_start_abort_idle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    compared++;
    if (snap() !== RESET_VEC) begin
      mismatched++;
      $display("[TB] FAIL start_abort_idle: got %h expected %h", snap(), RESET_VEC);
    end
    tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL start_abort_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      $display("[TB] random frame %0d", f);
      run_frame(2, 0, 0, 0, 1, 1'b1, 0, 0, 0);
    end
  endtask

  task automatic test_min_size();
    $display("[TB] minimum 3x3 image");
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if ({m_fill_req, m_fill_sel} !== {1'b1, 3'(1 << i)}) begin
        mismatched++;
        $display("[TB] FAIL min_fill: got req/sel=%b expected %b", {m_fill_req, m_fill_sel}, {1'b1, 3'(1 << i)});
      end
      m_fill_ack = 1'b1;
      tick();
      m_fill_ack = 1'b0;
    end
    compared++;
    if ({m_win_valid, m_win_last, m_col_idx, m_row_idx, m_row_sel, m_fill_req} !== 8'b1100_0010) begin
      mismatched++;
      $display("[TB] FAIL min_window: got %b expected 11000010",
               {m_win_valid, m_win_last, m_col_idx, m_row_idx, m_row_sel, m_fill_req});
    end
    m_out_ready = 1'b1;
    #1;
    compared++;
    if (m_rc_en !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL min_rc_en: got %b expected 1", m_rc_en);
    end
    tick();
    m_out_ready = 1'b0;
    compared++;
    if ({m_done, m_win_valid, m_fill_req} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL min_done: got done/valid/req=%b expected 100", {m_done, m_win_valid, m_fill_req});
    end
    tick();
    compared++;
    if ({m_busy, m_done} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL min_idle: got busy/done=%b expected 00", {m_busy, m_done});
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    m_start     = 1'b0;
    m_abort     = 1'b0;
    m_fill_ack  = 1'b0;
    m_out_ready = 1'b0;
    test_reset();
    test_default_frame();
    test_backpressure();
    test_abort();
    test_reset_mid_frame();
    test_ignored_inputs();
    test_start_abort_idle();
    test_random();
    test_min_size();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
